// File: rtl/booth_r4_mul_seq.sv
// booth_r4_mul_seq: iterative radix-4 Booth multiplier covering MUL/MULH/MULHSU/MULHU.
// Operands are extended to XLEN+2 bits so signed and unsigned forms share one
// datapath. Two product bits are retired per enabled clock, over N_STEP = XLEN/2+1 steps.
// Optional build macro: MUL_ZERO_BYPASS_EN. When it is defined, an operation with a
// zero operand skips the Booth loop and goes straight to DONE with a result of 0.
module booth_r4_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clk_en_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] multiplicand_i,
  input  logic [XLEN-1:0] multiplier_i,
  input  logic [1:0]      operation_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int N_STEP = XLEN/2 + 1;
  localparam int CW     = $clog2(N_STEP + 1);
  localparam logic [CW-1:0] LAST = CW'(N_STEP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN+2:0] p_q, p_d;   // partial product, one guard bit above 2B
  logic [XLEN+1:0] a_q, a_d;   // multiplier; fills with low product bits as it shifts
  logic            l_q, l_d;   // Booth look-behind bit
  logic [XLEN+1:0] b_q, b_d;   // extended multiplicand
  logic [XLEN-1:0] res_q, res_d;

  logic            accept;
  logic            s1, s2;
  logic [XLEN+2:0] bx, addend, sum, p_sh;
  logic [XLEN+1:0] a_sh;
  logic [XLEN-1:0] final_res;

  // Handshake and status outputs; ready_o follows ready_i while a result is pending
  always_comb begin
    ready_o  = (state_q == S_IDLE) | ((state_q == S_DONE) & ready_i);
    valid_o  = (state_q == S_DONE);
    busy_o   = (state_q != S_IDLE);
    result_o = res_q;
    accept   = valid_i & ready_o;
  end

  // One Booth step: select the digit's addend, accumulate, then shift {P,A,L} right by 2
  always_comb begin
    bx     = {b_q[XLEN+1], b_q};
    addend = '0;
    case ({a_q[1:0], l_q})
      3'b001, 3'b010: addend = bx;
      3'b011:         addend = {b_q, 1'b0};
      3'b100:         addend = -{b_q, 1'b0};
      3'b101, 3'b110: addend = -bx;
      default:        addend = '0;
    endcase
    sum  = p_q + addend;
    p_sh = {{2{sum[XLEN+2]}}, sum[XLEN+2:2]};
    a_sh = {sum[1:0], a_q[XLEN+1:2]};
    // low 2*XLEN product bits are {p_sh[XLEN-3:0], a_sh}
    final_res = (op_q == 2'b00) ? a_sh[XLEN-1:0]
                                : {p_sh[XLEN-3:0], a_sh[XLEN+1:XLEN]};
  end

  // Next-state logic: accept/load, iterate, hold the result until consumed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    p_d     = p_q;
    a_d     = a_q;
    l_d     = l_q;
    b_d     = b_q;
    res_d   = res_q;
    // rs1 is signed except for MULHU, rs2 is signed only for MUL/MULH
    s1      = (operation_i != 2'b11);
    s2      = ~operation_i[1];
    case (state_q)
      S_COMP: begin
        p_d   = p_sh;
        a_d   = a_sh;
        l_d   = a_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          res_d   = final_res;
        end
      end
      default: begin
        // a consumed result (or an unused encoding) returns to IDLE unless a new op is taken
        if (state_q != S_DONE || ready_i) state_d = S_IDLE;
        if (accept) begin
          b_d     = {{2{s1 & multiplicand_i[XLEN-1]}}, multiplicand_i};
          a_d     = {{2{s2 & multiplier_i[XLEN-1]}}, multiplier_i};
          p_d     = '0;
          l_d     = 1'b0;
          op_d    = operation_i;
          cnt_d   = '0;
          state_d = S_COMP;
`ifdef MUL_ZERO_BYPASS_EN
          // a zero operand makes the product zero, so the loop is skipped
          if (multiplicand_i == '0 || multiplier_i == '0) begin
            state_d = S_DONE;
            res_d   = '0;
          end
`endif
        end
      end
    endcase
  end

  // State registers; reset wins over the clock enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      p_q     <= '0;
      a_q     <= '0;
      l_q     <= 1'b0;
      b_q     <= '0;
      res_q   <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      p_q     <= p_d;
      a_q     <= a_d;
      l_q     <= l_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// tb_booth_r4_mul_seq: directed vector table plus hand-written stall/reset sequences.
module tb_booth_r4_mul_seq;

  logic        clk_i = 1'b0;
  logic        rst_i, clk_en_i, valid_i, ready_i;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] multiplicand_i, multiplier_i, result_o;
  logic [1:0]  operation_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  booth_r4_mul_seq #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
    .operation_i(operation_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // edges after the accept edge until the result is visible
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 0;
`endif
    return 17;
  endfunction

  // present an op for one edge; caller guarantees ready_o is high
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    operation_i    = op;
    multiplicand_i = a;
    multiplier_i   = b;
    valid_i        = 1'b1;
    @(posedge clk_i); #1;
    valid_i        = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, lat2;
    logic [31:0] held;
    vecs[0]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[4]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{2'b10, 32'h00000002, 32'h80000000, 32'h00000001};
    vecs[6]  = '{2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
    vecs[7]  = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[8]  = '{2'b01, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF};
    vecs[9]  = '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
    vecs[10] = '{2'b00, 32'h00000000, 32'h12345678, 32'h00000000};
    vecs[11] = '{2'b00, 32'h00000001, 32'h00000001, 32'h00000001};
    vecs[12] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[13] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[14] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};

    rst_i = 1'b1; clk_en_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    operation_i = 2'b00; multiplicand_i = '0; multiplier_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset ready_o", 32'(ready_o), 32'd1);
    chk("reset busy_o",  32'(busy_o),  32'd0);
    chk("reset result_o", result_o, 32'd0);

    // table: back-to-back ops with ready_i high
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].a, vecs[i].b)));
      chk($sformatf("vec%0d result", i), result_o, vecs[i].exp);
    end
    @(posedge clk_i); #1;  // drain the last result
    chk("idle after drain ready_o", 32'(ready_o), 32'd1);

    // downstream stall with a new op pending
    ready_i = 1'b0;
    issue(2'b00, 32'h00000007, 32'hFFFFFFFD);
    wait_valid(lat);
    chk("stall first latency", 32'(lat), 32'd17);
    held = result_o;
    chk("stall first result", held, 32'hFFFFFFEB);
    operation_i = 2'b11; multiplicand_i = 32'hFFFFFFFF; multiplier_i = 32'hFFFFFFFF;
    valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      chk($sformatf("stall c%0d valid_o", c), 32'(valid_o), 32'd1);
      chk($sformatf("stall c%0d result", c), result_o, 32'hFFFFFFEB);
      chk($sformatf("stall c%0d ready_o", c), 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    #1 chk("release ready_o comb", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("same-edge accept busy_o", 32'(busy_o), 32'd1);
    chk("same-edge accept valid_o", 32'(valid_o), 32'd0);
    wait_valid(lat);
    chk("b2b latency", 32'(lat), 32'd17);
    chk("b2b result", result_o, 32'hFFFFFFFE);
    @(posedge clk_i); #1;

    // clock-enable freeze mid-COMPUTE stretches latency by 3
    issue(2'b01, 32'h80000000, 32'h80000000);
    repeat (5) @(posedge clk_i);
    #1 clk_en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 clk_en_i = 1'b1;
    wait_valid(lat2);
    chk("clk_en latency", 32'(5 + 3 + lat2), 32'd20);
    chk("clk_en result", result_o, 32'h40000000);
    @(posedge clk_i); #1;

    // reset on the step-9 edge discards the operation
    issue(2'b00, 32'h00000003, 32'h00000005);
    repeat (8) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midrst ready_o", 32'(ready_o), 32'd1);
    chk("midrst valid_o", 32'(valid_o), 32'd0);
    chk("midrst busy_o",  32'(busy_o),  32'd0);
    chk("midrst result_o", result_o, 32'd0);
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_i); #1;
      if (valid_o) lat++;
    end
    chk("midrst no valid_o", 32'(lat), 32'd0);

    // the unit still works after the aborted op
    issue(2'b00, 32'h00000003, 32'h00000005);
    wait_valid(lat);
    chk("post-rst latency", 32'(lat), 32'd17);
    chk("post-rst result", result_o, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
